seq_detect_prog: RTL
====================

// Module: seq_detect_prog
// PURPOSE
//  Parametrised serial bit-pattern detector; successor to the fixed-pattern "1001" detector.
//  - PAT_W-bit pattern, programmable at runtime; default pattern out of reset.
//  - Selectable overlapping / non-overlapping match; per-bit valid qualifier; saturating match counter.
//  - Sits on a 1-bit serial stream; seq_detected feeds downstream framing/control logic.
// PARAMETERS
//  PAT_W    4        pattern length in bits (2..32)
//  DEF_PAT  4'b1001  pattern loaded at reset (PAT_W bits; first-received bit = MSB)
//  CNT_W    8        width of match counter
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  data          in   1      serial input bit
//  data_valid    in   1      data sampled only when 1
//  cfg_load      in   1      load cfg_pattern, flush history
//  cfg_pattern   in   PAT_W  new pattern (MSB = first bit)
//  overlap_en    in   1      1 = overlapping matches, 0 = non-overlapping
//  cnt_clr       in   1      synchronous clear of match_cnt
//  seq_detected  out  1      one-cycle match pulse (registered)
//  match_cnt     out  CNT_W  saturating count of matches
//  pattern_q     out  PAT_W  currently active pattern
// BEHAVIOUR
//  Reset (async, rst_n=0): hist=0, fill=0, pattern_q=DEF_PAT, seq_detected=0, match_cnt=0.
//  State: hist[PAT_W-1:0] shift reg; fill counter 0..PAT_W (saturates at PAT_W).
//  Sample edge (data_valid=1, cfg_load=0): hist_n={hist[PAT_W-2:0],data}; fill_n=min(fill+1,PAT_W).
//  Match: hit = data_valid & ~cfg_load & (fill_n==PAT_W) & (hist_n==pattern_q).
//  Latency: seq_detected=1 in the cycle after the edge sampling the last pattern bit; else 0.
//  On hit, overlap_en=1: hist/fill update normally (suffix may start next match).
//  On hit, overlap_en=0: hist<=0, fill<=0; the next match needs PAT_W fresh bits.
//  data_valid=0: hist, fill hold; seq_detected=0.
//  cfg_load=1: pattern_q<=cfg_pattern, hist<=0, fill<=0, no hit; same-cycle data ignored.
//  match_cnt: +1 per hit, saturates at 2^CNT_W-1.
//  cnt_clr=1: match_cnt<=0; on a simultaneous hit, match_cnt<=1.
//  overlap_en is sampled on each hit edge; changing it mid-stream takes effect at the next hit.
//  No false match before fill reaches PAT_W (all-zero pattern included).
// CONFIGURATION
//  SEQ_DETECT_MASK_EN defined: adds input cfg_mask [PAT_W-1:0], loaded with cfg_load
//    (reset value all-ones); hit compares (hist_n & mask_q)==(pattern_q & mask_q); 0 bits = don't-care.
//  Undefined: no cfg_mask port; exact full-width compare.
// STRUCTURE
//  Package seq_detect_pkg: PAT_W_MAX=32, default-pattern constant,
//    function sat_inc(cnt) for the counter.
//  Sub-module seq_hist_shift: shift register + fill counter, flush input.
//    Compare, counter and config registers stay in top.
// TESTING (default params unless noted)
//  Overlap=1, bits 1,0,0,1,0,0,1 -> pulses after bits 4 and 7; match_cnt=2.
//  Overlap=0, same stream -> pulse after bit 4 only; match_cnt=1.
//  Bits 1,0,0, then rst_n low 20ns, then bit 1 -> no pulse; all outputs at reset values.
//  1,0 / data_valid=0 for 3 cycles / 0,1 -> one pulse after final bit (gaps ignored).
//  cfg_load with 4'b0110, then 0,1,1,0,1,1,0 overlap=1 -> pattern_q=0110; pulses after bits 4, 7.
//  CNT_W=2, six matches -> match_cnt stays 3; cnt_clr with hit -> match_cnt=1.
//  MASK_EN: pattern 1001, mask 1001 -> stream 1,1,1,1 matches; mask all-ones -> no match.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants, types and helpers for the serial pattern detector
//
// Purpose : constants, match-mode type and saturating-increment helper.
//           Imported by seq_detect_prog, seq_detect_prog_if and seq_hist_shift.
// Contents: PAT_W_MAX     largest supported pattern length
//           CNT_W_MAX     largest supported match counter width
//           DEF_PATTERN   pattern loaded at reset (low PAT_W bits used)
//           match_mode_e  overlapping / non-overlapping match policy
//           sat_inc()     increment that sticks at a ceiling value

package seq_detect_pkg;

  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MAX = 32;

  // Classic "1001" pattern; the top truncates it to PAT_W bits.
  localparam logic [PAT_W_MAX-1:0] DEF_PATTERN = 32'h0000_0009;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } match_mode_e;

  // Returns cnt+1, or cnt unchanged once it has reached max_val.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic [CNT_W_MAX-1:0] max_val
  );
    if (cnt >= max_val) begin
      return cnt;
    end
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// rtl/seq_detect_prog_if.sv - stream, configuration and status bundle of the pattern detector
//
// Purpose : groups every non-clock/reset signal of seq_detect_prog.
//           master = stimulus side (drives stream/config), slave = detector.
// Signals : data, data_valid          serial bit and its qualifier
//           cfg_load, cfg_pattern     load a new pattern and flush history
//           cfg_mask                  compare mask (SEQ_DETECT_MASK_EN builds only)
//           overlap_en                1 = overlapping matches
//           cnt_clr                   clear the match counter
//           seq_detected              one-cycle registered match pulse
//           match_cnt                 saturating match count
//           pattern_q                 active pattern
// Build   : SEQ_DETECT_MASK_EN adds cfg_mask.

interface seq_detect_prog_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);

  logic             data;
  logic             data_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] cfg_mask;
`endif
  logic             overlap_en;
  logic             cnt_clr;
  logic             seq_detected;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] pattern_q;

  modport master (
`ifdef SEQ_DETECT_MASK_EN
    output cfg_mask,
`endif
    output data,
    output data_valid,
    output cfg_load,
    output cfg_pattern,
    output overlap_en,
    output cnt_clr,
    input  seq_detected,
    input  match_cnt,
    input  pattern_q
  );

  modport slave (
`ifdef SEQ_DETECT_MASK_EN
    input  cfg_mask,
`endif
    input  data,
    input  data_valid,
    input  cfg_load,
    input  cfg_pattern,
    input  overlap_en,
    input  cnt_clr,
    output seq_detected,
    output match_cnt,
    output pattern_q
  );

endinterface

// File: rtl/seq_hist_shift.sv
// rtl/seq_hist_shift.sv - bit history shift register with fill counter
//
// Purpose : keeps the last PAT_W accepted bits and how many have arrived
//           since the last flush (saturating at PAT_W).
// Ports   : clk       clock, rising edge
//           rst_n     asynchronous active-low reset
//           shift_en  accept bit_in this cycle
//           bit_in    serial bit
//           flush     clear history and fill (wins over shift_en)
//           hist_n    history as it will be after this edge (before flush)
//           full_n    fill will equal PAT_W after this edge (before flush)

module seq_hist_shift
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             flush,
  output logic [PAT_W-1:0] hist_n,
  output logic             full_n
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_n;

  // Next-state values are exported so the top can compare against the
  // history that includes the bit being sampled on this edge.
  always_comb begin
    hist_n = hist_q;
    fill_n = fill_q;
    if (shift_en) begin
      hist_n = {hist_q[PAT_W-2:0], bit_in};
      fill_n = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    end
  end

  assign full_n = (fill_n == FILL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (flush) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_n;
      fill_q <= fill_n;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-pattern detector with saturating match counter
//
// Purpose : detects a runtime-programmable PAT_W-bit pattern (first bit = MSB)
//           on a qualified serial stream, overlapping or non-overlapping,
//           pulses seq_detected one cycle after the completing bit and counts
//           matches in a saturating counter.
// Params  : PAT_W    pattern length (2..32)
//           DEF_PAT  pattern loaded at reset
//           CNT_W    match counter width (1..32)
// Ports   : clk      clock, rising edge
//           rst_n    asynchronous active-low reset
//           bus      seq_detect_prog_if.slave (stream, config, status)
// Build   : SEQ_DETECT_MASK_EN adds a per-bit compare mask (bus.cfg_mask),
//           loaded with cfg_load, all-ones at reset; 0 bits are don't-care.
//           Without it the compare is exact over the full width.

module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_detect_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pattern_q;
  logic             seq_detected_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] match_cnt_inc;

  logic [PAT_W-1:0] hist_n;
  logic             full_n;
  logic             shift_en;
  logic             pattern_eq;
  logic             hit;
  logic             flush;
  match_mode_e      mode;

`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] mask_q;
`endif

  // A load cycle swallows any same-cycle data bit.
  assign shift_en = bus.data_valid & ~bus.cfg_load;

`ifdef SEQ_DETECT_MASK_EN
  assign pattern_eq = ((hist_n & mask_q) == (pattern_q & mask_q));
`else
  assign pattern_eq = (hist_n == pattern_q);
`endif

  // full_n keeps short histories (including an all-zero one) from matching.
  assign hit  = shift_en & full_n & pattern_eq;
  assign mode = match_mode_e'(bus.overlap_en);

  // Non-overlapping mode restarts from an empty history after every match.
  assign flush = bus.cfg_load | (hit & (mode == MODE_NON_OVERLAP));

  assign match_cnt_inc = CNT_W'(sat_inc(32'(match_cnt_q), 32'(CNT_MAX)));

  seq_hist_shift #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .bit_in   (bus.data),
    .flush    (flush),
    .hist_n   (hist_n),
    .full_n   (full_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q      <= DEF_PAT;
`ifdef SEQ_DETECT_MASK_EN
      mask_q         <= '1;
`endif
      seq_detected_q <= 1'b0;
      match_cnt_q    <= '0;
    end else begin
      if (bus.cfg_load) begin
        pattern_q <= bus.cfg_pattern;
`ifdef SEQ_DETECT_MASK_EN
        mask_q    <= bus.cfg_mask;
`endif
      end

      seq_detected_q <= hit;

      // A clear coinciding with a match leaves that match counted.
      if (bus.cnt_clr) begin
        match_cnt_q <= hit ? CNT_W'(1) : '0;
      end else if (hit) begin
        match_cnt_q <= match_cnt_inc;
      end
    end
  end

  assign bus.seq_detected = seq_detected_q;
  assign bus.match_cnt    = match_cnt_q;
  assign bus.pattern_q    = pattern_q;

endmodule
